// File: rtl/arb_pkg.sv
// arb_pkg: definitions shared by the weighted round-robin arbiter files.
//   state_t           - arbiter FSM encoding (ST_IDLE = 1'b0, ST_GRANT = 1'b1)
//   clog2()           - elaboration-time ceiling log2, never smaller than 1
//   ARB_WEIGHT_FIELD  - extracts field k of width w from a packed weight vector
`ifndef ARB_PKG_SV
`define ARB_PKG_SV

`define ARB_WEIGHT_FIELD(vec, k, w) vec[(k)*(w) +: (w)]

package arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // At least one bit, so a 2-entry index or a TIMEOUT of 2 still gets a real counter.
   function automatic int clog2(input int value);
      int res;
      res = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            res = i + 1;
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

`endif

// File: rtl/rr_pick_next.sv
// rr_pick_next: combinational rotating-priority picker.
//   req    - request vector to choose from
//   ptr    - index that holds highest priority; search runs upward with wrap-around
//   found  - some request bit was set
//   sel    - one-hot winner (all zero when found is low)
//   sel_id - binary index of the winner (zero when found is low)
module rr_pick_next
   import arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            found,
   output logic [N-1:0]    sel,
   output logic [ID_W-1:0] sel_id
);

   logic            hit_s;
   logic [N-1:0]    sel_s;
   logic [ID_W-1:0] id_s;
   int              idx_s;

   // Walk the requesters starting at ptr; the first set bit wins.
   always_comb begin
      hit_s = 1'b0;
      sel_s = {N{1'b0}};
      id_s  = {ID_W{1'b0}};
      idx_s = 0;
      for (int i = 0; i < N; i++) begin
         idx_s = (int'(ptr) + i) % N;
         if (!hit_s && req[idx_s]) begin
            hit_s        = 1'b1;
            sel_s[idx_s] = 1'b1;
            id_s         = ID_W'(idx_s);
         end else begin
            hit_s = hit_s;
         end
      end
   end

   assign found  = hit_s;
   assign sel    = sel_s;
   assign sel_id = id_s;

endmodule

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with transaction-granular grants.
// The grantee keeps the resource for up to weight completed transactions
// (weight 0 counts as 1), and loses it early when it drops its request or
// holds the grant for TIMEOUT cycles without completing a transaction.
//   sys_clk_i     - clock, rising edge
//   rst_n_i       - asynchronous active-low reset
//   request_i     - level request per requester
//   done_i        - grantee finished one transaction this cycle
//   weight_i      - packed per-requester weights, field k at k*WEIGHT_W
//   respond_o     - registered one-hot grant
//   grant_valid_o - some grant is active
//   grant_id_o    - grantee index, holds its last value while idle
//   timeout_o     - one-cycle pulse after a forced release
module wrr_arbiter
   import arb_pkg::*;
#(
   parameter int   REQUIRE_NUM = 4,
   parameter int   WEIGHT_W    = 4,
   parameter int   TIMEOUT     = 1024,
   localparam int  ID_W        = clog2(REQUIRE_NUM)
) (
   input  logic                            sys_clk_i,
   input  logic                            rst_n_i,
   input  logic [REQUIRE_NUM-1:0]          request_i,
   input  logic                            done_i,
   input  logic [REQUIRE_NUM*WEIGHT_W-1:0] weight_i,
   output logic [REQUIRE_NUM-1:0]          respond_o,
   output logic                            grant_valid_o,
   output logic [ID_W-1:0]                 grant_id_o,
   output logic                            timeout_o
);

   localparam int                HOLD_W     = clog2(TIMEOUT);
   localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(TIMEOUT - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
   localparam logic [WEIGHT_W-1:0] CREDIT_ONE = WEIGHT_W'(1);
   localparam logic [ID_W-1:0]   ID_LAST    = ID_W'(REQUIRE_NUM - 1);
   localparam logic [ID_W-1:0]   ID_ONE     = ID_W'(1);

   state_t                 state_r;
   logic [ID_W-1:0]        ptr_r;
   logic [WEIGHT_W-1:0]    credit_r;
   logic [HOLD_W-1:0]      hold_cnt_r;

   logic                   in_grant_s;
   logic                   abandon_s;
   logic                   force_s;
   logic                   exhaust_s;
   logic                   release_s;
   logic [ID_W-1:0]        next_ptr_s;
   logic [ID_W-1:0]        pick_ptr_s;
   logic [REQUIRE_NUM-1:0] pick_req_s;
   logic                   found_s;
   logic [REQUIRE_NUM-1:0] sel_s;
   logic [ID_W-1:0]        sel_id_s;
   logic [WEIGHT_W-1:0]    new_weight_s;
   logic [WEIGHT_W-1:0]    load_credit_s;

   // Release decode (abandon beats timeout beats credit exhaustion) and picker inputs.
   always_comb begin
      in_grant_s   = (state_r == ST_GRANT);
      abandon_s    = in_grant_s && !request_i[grant_id_o] && !done_i;
      force_s      = in_grant_s && !abandon_s && (hold_cnt_r == HOLD_MAX) && !done_i;
      exhaust_s    = in_grant_s && done_i && (credit_r == CREDIT_ONE);
      release_s    = abandon_s || force_s || exhaust_s;
      next_ptr_s   = (grant_id_o == ID_LAST) ? {ID_W{1'b0}} : (grant_id_o + ID_ONE);
      // While granting, the picker is only consumed on a release, so it can always
      // search from the post-release pointer; an abandoning grantee is excluded.
      pick_ptr_s   = in_grant_s ? next_ptr_s : ptr_r;
      pick_req_s   = abandon_s ? (request_i & ~respond_o) : request_i;
      new_weight_s  = `ARB_WEIGHT_FIELD(weight_i, int'(sel_id_s), WEIGHT_W);
      load_credit_s = (new_weight_s == {WEIGHT_W{1'b0}}) ? CREDIT_ONE : new_weight_s;
   end

   rr_pick_next #(
      .N    (REQUIRE_NUM),
      .ID_W (ID_W)
   ) u_pick (
      .req    (pick_req_s),
      .ptr    (pick_ptr_s),
      .found  (found_s),
      .sel    (sel_s),
      .sel_id (sel_id_s)
   );

   // Arbiter FSM with credit/hold counters and registered grant outputs.
   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_r       <= ST_IDLE;
         ptr_r         <= {ID_W{1'b0}};
         credit_r      <= {WEIGHT_W{1'b0}};
         hold_cnt_r    <= {HOLD_W{1'b0}};
         respond_o     <= {REQUIRE_NUM{1'b0}};
         grant_valid_o <= 1'b0;
         grant_id_o    <= {ID_W{1'b0}};
         timeout_o     <= 1'b0;
      end else begin
         timeout_o <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (found_s) begin
                  state_r       <= ST_GRANT;
                  respond_o     <= sel_s;
                  grant_valid_o <= 1'b1;
                  grant_id_o    <= sel_id_s;
                  credit_r      <= load_credit_s;
                  hold_cnt_r    <= {HOLD_W{1'b0}};
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (release_s) begin
                  ptr_r     <= next_ptr_s;
                  timeout_o <= force_s;
                  if (found_s) begin
                     // Hand over on the same edge: no idle gap, no overlap.
                     respond_o     <= sel_s;
                     grant_valid_o <= 1'b1;
                     grant_id_o    <= sel_id_s;
                     credit_r      <= load_credit_s;
                     hold_cnt_r    <= {HOLD_W{1'b0}};
                  end else begin
                     state_r       <= ST_IDLE;
                     respond_o     <= {REQUIRE_NUM{1'b0}};
                     grant_valid_o <= 1'b0;
                  end
               end else if (done_i) begin
                  credit_r   <= credit_r - CREDIT_ONE;
                  hold_cnt_r <= {HOLD_W{1'b0}};
               end else begin
                  hold_cnt_r <= hold_cnt_r + HOLD_ONE;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               respond_o     <= {REQUIRE_NUM{1'b0}};
               grant_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
